// File: rtl/sram_banked_pkg.sv
// Shared types and elaboration-time helpers for the two-dimensional banked SRAM.
// Holds the controller state enum, derived-width functions and a parameter
// legality check evaluated when the top is elaborated.
package sram_banked_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Width of one bit-slice bank.
    function automatic int bank_data_width(input int data_width, input int num_h_banks);
        return data_width / num_h_banks;
    endfunction

    // Local address width inside one vertical partition.
    function automatic int bank_addr_width(input int addr_width, input int num_v_banks);
        return addr_width - $clog2(num_v_banks);
    endfunction

    // Number of write-mask bits across the full word.
    function automatic int num_wmask(input int data_width, input int wmask_gran);
        return data_width / wmask_gran;
    endfunction

    // True when the parameter set describes a buildable array.
    function automatic bit params_legal(input int data_width, input int addr_width,
                                        input int num_h_banks, input int num_v_banks,
                                        input int wmask_gran);
        bit ok;
        ok = 1'b1;
        if (num_h_banks < 1 || wmask_gran < 1 || num_v_banks < 1) begin
            ok = 1'b0;
        end else begin
            if ((data_width % num_h_banks) != 0) ok = 1'b0;
            if (((data_width / num_h_banks) % wmask_gran) != 0) ok = 1'b0;
            if ((num_v_banks & (num_v_banks - 1)) != 0) ok = 1'b0;
            if (addr_width <= $clog2(num_v_banks)) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/sram_banked_2d_top_bank.sv
// Behavioural single-port bank standing in for one compiled SRAM macro.
// Inputs are sampled on the rising edge; reads return one cycle later and
// the output keeps its last read value across writes and idle cycles.
module sram_bank_model #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 11,
    parameter int WMASK_GRAN = 8,
    parameter int NUM_WMASK  = DATA_WIDTH / WMASK_GRAN
) (
    input  logic                  clk_i,
    input  logic                  csb_i,
    input  logic                  web_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [NUM_WMASK-1:0]  wmask_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_q;

    // Selected access: masked byte write, or read into the output latch.
    always_ff @(posedge clk_i) begin
        if (!csb_i) begin
            if (!web_i) begin
                for (int i = 0; i < NUM_WMASK; i++) begin
                    if (wmask_i[i]) begin
                        mem_q[addr_i][i*WMASK_GRAN +: WMASK_GRAN] <= din_i[i*WMASK_GRAN +: WMASK_GRAN];
                    end
                end
            end else begin
                dout_q <= mem_q[addr_i];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/sram_banked_2d_top.sv
// Two-dimensional banked SRAM top: NUM_H_BANKS bit-slices by NUM_V_BANKS
// address partitions, byte-masked writes, registered read return with a
// valid strobe and a post-reset zero-fill sequencer.
// Optional build macro SRAM_BANKED_DOUT_REG_EN adds a flop after the row mux
// (read latency 2 instead of 1).
module sram_banked_2d_top
    import sram_banked_pkg::*;
#(
    parameter int DATA_WIDTH  = 1024,
    parameter int ADDR_WIDTH  = 13,
    parameter int NUM_H_BANKS = 8,
    parameter int NUM_V_BANKS = 4,
    parameter int WMASK_GRAN  = 8,
    parameter int BANK_DATA_WIDTH = bank_data_width(DATA_WIDTH, NUM_H_BANKS),
    parameter int BANK_ADDR_WIDTH = bank_addr_width(ADDR_WIDTH, NUM_V_BANKS),
    parameter int NUM_WMASK       = num_wmask(DATA_WIDTH, WMASK_GRAN)
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [NUM_WMASK-1:0]  wmask0,
    output logic                  ready0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid
);

    localparam int VSEL_W    = $clog2(NUM_V_BANKS);
    localparam int SEL_W     = (VSEL_W > 0) ? VSEL_W : 1;
    localparam int BANK_WMSK = NUM_WMASK / NUM_H_BANKS;
    localparam logic [BANK_ADDR_WIDTH-1:0] CNT_MAX = '1;

    if (!params_legal(DATA_WIDTH, ADDR_WIDTH, NUM_H_BANKS, NUM_V_BANKS, WMASK_GRAN)) begin : g_bad_params
        $error("sram_banked_2d_top: illegal parameter combination");
    end

    state_e                     state_q;
    logic [BANK_ADDR_WIDTH-1:0] cnt_q;
    logic                       ready_q;

    logic [SEL_W-1:0]           req_vsel;
    logic                       req_rd;
    logic [NUM_V_BANKS-1:0]     bank_csb;
    logic                       bank_web;
    logic [BANK_ADDR_WIDTH-1:0] bank_addr;
    logic [DATA_WIDTH-1:0]      bank_din;
    logic [NUM_WMASK-1:0]       bank_wmask;
    logic [DATA_WIDTH-1:0]      row_dout [NUM_V_BANKS];
    logic [DATA_WIDTH-1:0]      mux_dout;

    logic                       rd_vld_d, rd_vld_q;
    logic [SEL_W-1:0]           rd_sel_d, rd_sel_q;

    // Controller: zero-fill every local address once, then accept requests forever.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready0 = ready_q;

    if (VSEL_W == 0) begin : g_vsel_single
        assign req_vsel = '0;
    end else begin : g_vsel_multi
        assign req_vsel = addr0[ADDR_WIDTH-1 -: VSEL_W];
    end

    assign req_rd = ready_q && !csb0 && web0;

    // Bank steering: broadcast zero-fill during init, otherwise select one row.
    always_comb begin
        bank_csb   = '1;
        bank_web   = web0;
        bank_addr  = addr0[BANK_ADDR_WIDTH-1:0];
        bank_din   = din0;
        bank_wmask = wmask0;
        if (state_q == ST_INIT) begin
            bank_csb   = '0;
            bank_web   = 1'b0;
            bank_addr  = cnt_q;
            bank_din   = '0;
            bank_wmask = '1;
        end else if (!csb0) begin
            bank_csb[req_vsel] = 1'b0;
        end
    end

    for (genvar v = 0; v < NUM_V_BANKS; v++) begin : g_row
        for (genvar h = 0; h < NUM_H_BANKS; h++) begin : g_col
            sram_bank_model #(
                .DATA_WIDTH (BANK_DATA_WIDTH),
                .ADDR_WIDTH (BANK_ADDR_WIDTH),
                .WMASK_GRAN (WMASK_GRAN),
                .NUM_WMASK  (BANK_WMSK)
            ) u_bank (
                .clk_i   (clk0),
                .csb_i   (bank_csb[v]),
                .web_i   (bank_web),
                .addr_i  (bank_addr),
                .din_i   (bank_din[h*BANK_DATA_WIDTH +: BANK_DATA_WIDTH]),
                .wmask_i (bank_wmask[h*BANK_WMSK +: BANK_WMSK]),
                .dout_o  (row_dout[v][h*BANK_DATA_WIDTH +: BANK_DATA_WIDTH])
            );
        end
    end

    // Next read-pipeline state: flag accepted reads and remember their row.
    always_comb begin
        rd_vld_d = req_rd;
        rd_sel_d = rd_sel_q;
        if (req_rd) begin
            rd_sel_d = req_vsel;
        end
    end

    // Read-return tracking; reset drops any read still in flight.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            rd_vld_q <= 1'b0;
            rd_sel_q <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign mux_dout = row_dout[rd_sel_q];

`ifdef SRAM_BANKED_DOUT_REG_EN
    logic [DATA_WIDTH-1:0] dout_d, dout_q;
    logic                  vld_out_q;

    assign dout_d = rd_vld_q ? mux_dout : dout_q;

    // Output flop after the row mux; it only loads on a returning read.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            dout_q    <= '0;
            vld_out_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            vld_out_q <= rd_vld_q;
        end
    end

    assign dout0       = dout_q;
    assign dout0_valid = vld_out_q;
`else
    logic [DATA_WIDTH-1:0] hold_d, hold_q;

    assign hold_d = rd_vld_q ? mux_dout : hold_q;

    // Hold register keeps the last returned word visible between reads.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign dout0       = rd_vld_q ? mux_dout : hold_q;
    assign dout0_valid = rd_vld_q;
`endif

endmodule

// File: tb/tb_sram_banked_2d_top.sv
// Randomised and directed bench for sram_banked_2d_top (32-bit word,
// 64 words, 2x4 banks). A word-level memory model predicts ready0,
// dout0_valid and dout0 every cycle; directed scenarios pin literal values.
module tb_sram_banked_2d_top;

`ifdef SRAM_BANKED_DOUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int WORDS_PER_BANK = 16;

    logic        clk0 = 1'b0;
    logic        rst0_n = 1'b1;
    logic        csb0 = 1'b1;
    logic        web0 = 1'b1;
    logic [5:0]  addr0 = '0;
    logic [31:0] din0 = '0;
    logic [3:0]  wmask0 = '0;
    logic        ready0;
    logic [31:0] dout0;
    logic        dout0_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    sram_banked_2d_top #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (6),
        .NUM_H_BANKS (2),
        .NUM_V_BANKS (4),
        .WMASK_GRAN  (8)
    ) dut (
        .clk0        (clk0),
        .rst0_n      (rst0_n),
        .csb0        (csb0),
        .web0        (web0),
        .addr0       (addr0),
        .din0        (din0),
        .wmask0      (wmask0),
        .ready0      (ready0),
        .dout0       (dout0),
        .dout0_valid (dout0_valid)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [64];
    int          m_init_left = WORDS_PER_BANK;
    bit          exp_ready = 1'b0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_dout = '0;
    logic [31:0] pend_d [$];
    int          pend_left [$];
    bit          m_acc;

    initial foreach (m_mem[i]) m_mem[i] = '0;

    always @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            m_init_left = WORDS_PER_BANK;
            exp_ready   = 1'b0;
            exp_valid   = 1'b0;
            exp_dout    = '0;
            pend_d.delete();
            pend_left.delete();
            foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            m_acc = exp_ready && !csb0;
            if (m_acc && web0) begin
                pend_d.push_back(m_mem[addr0]);
                pend_left.push_back(LAT);
            end else if (m_acc) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) m_mem[addr0][8*b +: 8] = din0[8*b +: 8];
            end
            foreach (pend_left[i]) pend_left[i] = pend_left[i] - 1;
            exp_valid = 1'b0;
            if (pend_left.size() > 0 && pend_left[0] == 0) begin
                exp_valid = 1'b1;
                exp_dout  = pend_d.pop_front();
                void'(pend_left.pop_front());
            end
            if (m_init_left > 0) begin
                m_init_left--;
                if (m_init_left == 0) exp_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk0) begin
        if (chk_en) begin
            check("ready0", {31'd0, ready0}, {31'd0, exp_ready});
            check("dout0_valid", {31'd0, dout0_valid}, {31'd0, exp_valid});
            check("dout0", dout0, exp_dout);
        end
    end

    // Record every returned word with the cycle it appeared.
    logic [31:0] got [$];
    int          got_cyc [$];
    always @(negedge clk0) begin
        if (dout0_valid) begin
            got.push_back(dout0);
            got_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit c, input bit w, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        csb0 = c; web0 = w; addr0 = a; din0 = d; wmask0 = m;
        @(negedge clk0);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        drive(1'b0, 1'b0, a, d, m);
    endtask

    task automatic rd(input logic [5:0] a);
        drive(1'b0, 1'b1, a, $urandom, 4'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 6'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready0 !== 1'b1 && n < 40) begin
            @(posedge clk0);
            n++;
            @(negedge clk0);
            #1;
        end
    endtask

    task automatic do_reset();
        int n;
        rst0_n = 1'b0;
        idle(2);
        rst0_n = 1'b1;
        wait_ready(n);
        check("init_cycles", n, WORDS_PER_BANK);
    endtask

    logic [31:0] exp3 [4];
    logic [5:0]  adr3 [4];
    int          n_left;
    int          t_rd;
    logic [5:0]  ra;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst0_n = 1'b0;
        @(negedge clk0);
        #1;
        chk_en = 1'b1;
        check("reset_ready0", {31'd0, ready0}, 32'd0);
        check("reset_valid", {31'd0, dout0_valid}, 32'd0);
        check("reset_dout0", dout0, 32'd0);

        // 1. release reset, init length, everything reads zero
        do_reset();
        got.delete(); got_cyc.delete();
        for (int a = 0; a < 64; a++) rd(6'(a));
        idle(LAT + 1);
        check("s1_read_count", got.size(), 64);
        foreach (got[i]) check("s1_zero", got[i], 32'h0);

        // 2. requests during init are ignored
        rst0_n = 1'b0;
        idle(2);
        rst0_n = 1'b1;
        got.delete(); got_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 2) rd(6'(5 * i + 3));
            else wr(6'(5 * i + 3), 32'hDEADBEEF, 4'hF);
        end
        idle(1);
        wait_ready(n_left);
        check("s2_init_remaining", n_left, WORDS_PER_BANK - 13);
        check("s2_no_valid_in_init", got.size(), 0);
        for (int i = 0; i < 12; i++) rd(6'(5 * i + 3));
        idle(LAT + 1);
        check("s2_read_count", got.size(), 12);
        foreach (got[i]) check("s2_zero", got[i], 32'h0);

        // 3. one word in each vertical bank, back-to-back reads
        exp3[0] = 32'h11111111; exp3[1] = 32'h22222222;
        exp3[2] = 32'h33333333; exp3[3] = 32'h44444444;
        adr3[0] = 6'd5; adr3[1] = 6'd21; adr3[2] = 6'd37; adr3[3] = 6'd53;
        for (int i = 0; i < 4; i++) wr(adr3[i], exp3[i], 4'hF);
        got.delete(); got_cyc.delete();
        t_rd = cyc + 1;
        for (int i = 0; i < 4; i++) rd(adr3[i]);
        idle(LAT + 2);
        check("s3_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check("s3_data", got[i], exp3[i]);
            check("s3_cycle", got_cyc[i], t_rd + i + LAT - 1);
        end

        // 4. byte mask merge
        wr(6'd7, 32'hAABBCCDD, 4'hF);
        wr(6'd7, 32'h11223344, 4'b0101);
        wr(6'd8, 32'h55555555, 4'h0);
        got.delete(); got_cyc.delete();
        rd(6'd7);
        rd(6'd8);
        idle(LAT + 1);
        check("s4_count", got.size(), 2);
        if (got.size() == 2) begin
            check("s4_mask_merge", got[0], 32'hAA22CC44);
            check("s4_zero_mask", got[1], 32'h0);
        end

        // 5. read-after-write at top address, then hold
        got.delete(); got_cyc.delete();
        wr(6'd63, 32'hCAFEF00D, 4'hF);
        t_rd = cyc + 1;
        rd(6'd63);
        idle(LAT);
        check("s5_count", got.size(), 1);
        if (got.size() == 1) begin
            check("s5_raw", got[0], 32'hCAFEF00D);
            check("s5_latency", got_cyc[0], t_rd + LAT - 1);
        end
        for (int i = 0; i < 5; i++) begin
            check("s5_hold_dout", dout0, 32'hCAFEF00D);
            check("s5_hold_valid", {31'd0, dout0_valid}, 32'd0);
            idle(1);
        end

        // 6. reset right after a read is accepted
        got.delete(); got_cyc.delete();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 6'd63;
        @(posedge clk0);
        #1;
        rst0_n = 1'b0;
        csb0 = 1'b1;
        @(negedge clk0);
        #1;
        check("s6_valid", {31'd0, dout0_valid}, 32'd0);
        check("s6_dout0", dout0, 32'h0);
        idle(2);
        rst0_n = 1'b1;
        wait_ready(n_left);
        check("s6_init_cycles", n_left, WORDS_PER_BANK);
        check("s6_dropped", got.size(), 0);
        rd(6'd63);
        rd(6'd5);
        idle(LAT + 1);
        check("s6_count", got.size(), 2);
        foreach (got[i]) check("s6_rezeroed", got[i], 32'h0);

        // 7. randomised traffic with one reset in the middle
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            ra = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                              : {2'($urandom_range(0, 3)), 4'($urandom_range(14, 15))};
            drive(($urandom_range(0, 3) == 0), 1'($urandom), ra, $urandom, 4'($urandom));
        end
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_banked_2d_top.md
Name: sram_banked_2d_top

Overview:
Parametrised successor to the horizontal-only multi-bank SRAM top. It tiles single-port OpenRAM-style banks in two dimensions:
- NUM_H_BANKS bit-slices across the word.
- NUM_V_BANKS address partitions, selected by the upper address bits.

It adds per-byte write masking, a registered read-return path with a valid strobe, and a post-reset zero-initialisation sequencer. It sits between the compiler-generated bank macros and the client logic.

Parameters:
DATA_WIDTH, 1024, full word width; divisible by NUM_H_BANKS.
ADDR_WIDTH, 13, word address width.
NUM_H_BANKS, 8, bit-slice banks per row.
NUM_V_BANKS, 4, address-partition banks; power of 2, >=1.
WMASK_GRAN, 8, bits per write-mask bit; divides DATA_WIDTH/NUM_H_BANKS.
BANK_DATA_WIDTH, DATA_WIDTH/NUM_H_BANKS, derived.
BANK_ADDR_WIDTH, ADDR_WIDTH-$clog2(NUM_V_BANKS), derived.
NUM_WMASK, DATA_WIDTH/WMASK_GRAN, derived.

Ports:
clk0  input  1  clock.
rst0_n  input  1  asynchronous active-low reset.
csb0  input  1  active-low request strobe.
web0  input  1  0=write, 1=read.
addr0  input  ADDR_WIDTH  word address; addr0[ADDR_WIDTH-1:BANK_ADDR_WIDTH] selects vertical bank.
din0  input  DATA_WIDTH  write data.
wmask0  input  NUM_WMASK  write-mask bits; wmask0[i] enables din0[i*WMASK_GRAN +: WMASK_GRAN].
ready0  output  1  high when requests are accepted.
dout0  output  DATA_WIDTH  read data.
dout0_valid  output  1  one-cycle strobe marking new dout0.

Behaviour:
- Interface: one clock, clk0; reset is asynchronous and active-low, rst0_n.
- Reset values: ready0=0, dout0_valid=0, dout0=0; FSM=INIT, init counter=0; read pipeline cleared.
- FSM INIT:
  - Counter cnt runs 0..2^BANK_ADDR_WIDTH-1.
  - Each cycle, every bank (all H, all V) is written with zero at cnt, all mask bits set.
  - On cnt==max, go to READY the next cycle.
  - Init takes 2^BANK_ADDR_WIDTH cycles after reset release.
- FSM READY: ready0=1. No exit except reset.
- Requests in INIT: csb0=0 while ready0=0 is ignored. No bank access, no dout0_valid.
- Accepted request: csb0=0 && ready0=1 at rising edge T.
  - Only the vertical bank v=addr0[MSBs] is chip-selected; the others are held with csb=1.
  - All H banks of row v receive the same bank address, web0 and csb.
  - Each H bank h gets din0 slice [h*BANK_DATA_WIDTH +: BANK_DATA_WIDTH] and the matching wmask0 slice.
- Write (web0=0): only masked-in bytes change. No dout0_valid. dout0 holds its previous value.
- Read (web0=1):
  - v is captured in rd_sel_q at T.
  - At T+1, dout0_valid=1 and dout0 = concatenation of row rd_sel_q outputs, bank H-1 in the MSBs.
  - Latency is 1 cycle.
  - A hold register captures dout0 on valid; dout0 stays stable until the next valid.
- Back-to-back: one request per cycle, fully pipelined. Read at T and read at T+1 give valids at T+1 and T+2.
- Read-after-write: a read at T+1 of an address written at T returns the new data.
- Reset mid-operation: the in-flight read is dropped (no valid), the FSM returns to INIT, and the array is re-zeroed.
- Boundaries:
  - NUM_V_BANKS=1: no select bits; row 0 is always selected.
  - Highest address 2^ADDR_WIDTH-1 maps to bank NUM_V_BANKS-1, local address max.
  - wmask0=0 on a write is a legal no-op.

Optional Feature:
SRAM_BANKED_DOUT_REG_EN:
- Defined: an extra output register stage is added after the bank mux.
  - Read latency is 2; dout0_valid at T+2.
  - dout0 comes straight from a flop (timing closure for wide muxes).
- Undefined: latency 1 as above.
- All other behaviour is identical in both cases.

Decomposition:
- Package sram_banked_pkg:
  - FSM state enum {INIT, READY}.
  - Functions computing BANK_DATA_WIDTH, BANK_ADDR_WIDTH, NUM_WMASK.
  - Elaboration-time parameter legality checks.
- Sub-module sram_bank_model:
  - Behavioural single-port bank with csb/web/wmask, registered inputs and 1-cycle read; dout unchanged on writes.
  - Instantiated NUM_H_BANKS x NUM_V_BANKS times via generate.
  - Swapped for the compiled macro in synthesis.

Test Plan:
Params for all scenarios: DATA_WIDTH=32, ADDR_WIDTH=6, NUM_H_BANKS=2, NUM_V_BANKS=4, WMASK_GRAN=8 (16 words/bank).
1. Release reset:
   - ready0=0 for exactly 16 cycles, then 1.
   - Read of any address 0..63 returns 0x00000000.
2. Requests during INIT:
   - csb0=0 with writes of 0xDEADBEEF during init.
   - Post-init reads of those addresses return 0 and no dout0_valid is raised.
3. Vertical banks:
   - Write 0x11111111 to addr 5, 0x22222222 to addr 21, 0x33333333 to addr 37, 0x44444444 to addr 53.
   - Back-to-back reads return each value on consecutive cycles, dout0_valid high 4 cycles.
4. Byte mask:
   - Write addr 7 = 0xAABBCCDD with mask 4'hF, then 0x11223344 with mask 4'b0101.
   - Read returns 0xAA22CC44.
5. Read-after-write and hold:
   - Write addr 63 = 0xCAFEF00D at T, read at T+1: dout0=0xCAFEF00D, valid at T+2.
   - Idle 5 cycles: dout0 unchanged, valid=0.
6. Reset mid-read:
   - Assert rst0_n low the cycle after a read request: no dout0_valid, dout0=0.
   - Re-init runs for 16 cycles; prior data reads as 0.
   - Repeat scenarios 3 and 5 with SRAM_BANKED_DOUT_REG_EN defined: latency 2.
